tri_state_selector: RTL and testbench



---
 rtl/tri_state_selector.sv | 43 ++++
 tb/tb_tri_state_selector.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tri_state_selector.sv
// Registered three-state selector: fixed-priority requests (in0 > in1 > in2)
// pick a one-hot state each clock; no request holds, illegal codes recover to state 0.
module tri_state_selector #(
  parameter int RESET_STATE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic state0,
  output logic state1,
  output logic state2
);

  // Out-of-range RESET_STATE values fall back to state 0.
  localparam logic [2:0] RST_ONEHOT = (RESET_STATE == 1) ? 3'b010 :
                                      (RESET_STATE == 2) ? 3'b100 : 3'b001;

  logic [2:0] q;
  logic [2:0] nxt;
  logic       q_legal;

  assign q_legal = (q == 3'b001) || (q == 3'b010) || (q == 3'b100);

  always_comb begin
    nxt = q;
    if (in0)           nxt = 3'b001;
    else if (in1)      nxt = 3'b010;
    else if (in2)      nxt = 3'b100;
    else if (!q_legal) nxt = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= RST_ONEHOT;
    else     q <= nxt;
  end

  assign state0 = q[0];
  assign state1 = q[1];
  assign state2 = q[2];

endmodule

// File: tb/tb_tri_state_selector.sv
// Self-checking bench for tri_state_selector: directed scenarios plus a
// randomized run against a state-index reference model.
module tb_tri_state_selector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in0 = 1'b0, in1 = 1'b0, in2 = 1'b0;
  logic state0, state1, state2;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  tri_state_selector #(.RESET_STATE(0)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2),
    .state0(state0), .state1(state1), .state2(state2)
  );

  always #5 clk = ~clk;

  // Reference: state as an index; priority picks the lowest-numbered request.
  task automatic tick();
    @(posedge clk);
    if (rst)      model = 0;
    else if (in0) model = 0;
    else if (in1) model = 1;
    else if (in2) model = 2;
    #1;
  endtask

  function automatic logic [2:0] expv();
    logic [2:0] one;
    one = 3'b001;
    return one << model;
  endfunction

  task automatic drive(input logic r, input logic a, input logic b, input logic c);
    rst = r; in0 = a; in1 = b; in2 = c;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b001) begin
      errors++; $display("FAIL reset: got %b want 001", {state2, state1, state0});
    end
    drive(0, 0, 0, 0); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b001) begin
      errors++; $display("FAIL reset_hold: got %b want 001", {state2, state1, state0});
    end
  endtask

  task automatic test_prio01();
    drive(0, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({state2, state1, state0} !== 3'b001) begin
        errors++; $display("FAIL prio01[%0d]: got %b want 001", i, {state2, state1, state0});
      end
    end
  endtask

  task automatic test_prio12();
    drive(0, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({state2, state1, state0} !== 3'b010) begin
        errors++; $display("FAIL prio12[%0d]: got %b want 010", i, {state2, state1, state0});
      end
    end
  endtask

  task automatic test_single_hold();
    drive(0, 0, 0, 1); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b100) begin
      errors++; $display("FAIL single_in2: got %b want 100", {state2, state1, state0});
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({state2, state1, state0} !== 3'b100) begin
        errors++; $display("FAIL hold[%0d]: got %b want 100", i, {state2, state1, state0});
      end
    end
    drive(0, 0, 1, 0); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b010) begin
      errors++; $display("FAIL single_in1: got %b want 010", {state2, state1, state0});
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 1); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b100) begin
      errors++; $display("FAIL mid_pre: got %b want 100", {state2, state1, state0});
    end
    drive(1, 0, 0, 1); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b001) begin
      errors++; $display("FAIL mid_rst: got %b want 001", {state2, state1, state0});
    end
    drive(0, 0, 0, 1); tick();
    checks++;
    if ({state2, state1, state0} !== 3'b100) begin
      errors++; $display("FAIL mid_release: got %b want 100", {state2, state1, state0});
    end
  endtask

  task automatic test_random();
    int bad_sum, bad_model;
    bad_sum = 0; bad_model = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      tick();
      checks++;
      if (int'(state0) + int'(state1) + int'(state2) !== 1) begin
        errors++;
        if (bad_sum < 5)
          $display("FAIL rand_onehot[%0d]: got %b want exactly one bit set", i, {state2, state1, state0});
        bad_sum++;
      end
      checks++;
      if ({state2, state1, state0} !== expv()) begin
        errors++;
        if (bad_model < 5)
          $display("FAIL rand_model[%0d]: got %b want %b", i, {state2, state1, state0}, expv());
        bad_model++;
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    // Let one unchecked edge pass so the pre-reset value is never compared.
    @(posedge clk); #1;
    test_reset();
    test_prio01();
    test_prio12();
    test_single_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
